// File: rtl/ltpi_pkg.sv
// Shared LTPI data-channel types: response payload, arbiter FSM encoding and requester limit.
// Pure declarations; no logic, no latency, no flow control.
package ltpi_pkg;

  localparam int DATA_CHNL_ARB_MAX_REQ = 8;

  typedef struct packed {
    logic [7:0]  command;
    logic [7:0]  tag;
    logic [31:0] data;
  } Data_channel_payload_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OFFER = 2'd1,
    ARB_GAP   = 2'd2
  } data_chnl_arb_fsm_t;

endpackage

// File: rtl/ltpi_rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping modulo N.
// Zero latency; no flow control, the caller decides when the result is used.
module ltpi_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             found,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    found     = 1'b0;
    grant_oh  = '0;
    grant_idx = '0;
    idx       = '0;
    // Offset 1..N so last_grant itself is examined last.
    for (int i = 1; i <= N; i++) begin
      idx = IDX_W'((int'(last_grant) + i) % N);
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mgmt_data_channel_resp_arbiter.sv
// Round-robin arbiter feeding one data-channel response hold register, with offer timeout and grant stats.
// Capture 1 cycle after eligible req_valid; offer held until resp_ack or timeout, then one gap cycle.
module mgmt_data_channel_resp_arbiter
  import ltpi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  Data_channel_payload_t [NUM_REQ-1:0]  req_payload,
  input  logic [NUM_REQ-1:0]                   req_en,
  output logic [NUM_REQ-1:0]                   req_ack,
  output logic                                 resp_valid,
  output Data_channel_payload_t                resp,
  input  logic                                 resp_ack,
  input  logic                                 data_channel_rst,
  input  logic                                 err_clr,
  output logic [NUM_REQ-1:0]                   timeout_err,
  output logic [NUM_REQ-1:0][CNT_W-1:0]        grant_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  data_chnl_arb_fsm_t state, state_nxt;

  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   cur;
  logic [TMR_W-1:0]   timer;
  logic [NUM_REQ-1:0] cur_oh;
  logic               pick_found;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               capture;
  logic               deliver;
  logic               expire;

  ltpi_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req_valid & req_en),
    .last_grant (last_grant),
    .found      (pick_found),
    .grant_oh   (pick_oh),
    .grant_idx  (pick_idx)
  );

  assign cur_oh = NUM_REQ'(1) << cur;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    deliver   = 1'b0;
    expire    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          capture   = 1'b1;
          state_nxt = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        // An ack landing in the last allowed cycle still counts as a delivery.
        if (resp_ack) begin
          deliver   = 1'b1;
          state_nxt = ARB_GAP;
        end else if ((TIMEOUT_CYCLES != 0) && (timer == TMR_LAST)) begin
          expire    = 1'b1;
          state_nxt = ARB_GAP;
        end
      end
      ARB_GAP:  state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
    if (data_channel_rst) begin
      state_nxt = ARB_IDLE;
      capture   = 1'b0;
      deliver   = 1'b0;
      expire    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      resp_valid  <= 1'b0;
      req_ack     <= '0;
      resp        <= '0;
      timeout_err <= '0;
      grant_cnt   <= '0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      cur         <= '0;
      timer       <= '0;
    end else begin
      state   <= state_nxt;
      req_ack <= capture ? pick_oh : '0;

      if (capture) begin
        resp       <= req_payload[pick_idx];
        resp_valid <= 1'b1;
        cur        <= pick_idx;
      end else if (deliver || expire || data_channel_rst) begin
        resp_valid <= 1'b0;
      end

      if (capture || data_channel_rst) begin
        timer <= '0;
      end else if (state == ARB_OFFER) begin
        timer <= timer + 1'b1;
      end

      if (deliver) begin
        grant_cnt[cur] <= grant_cnt[cur] + 1'b1;
      end
      if (deliver || expire) begin
        last_grant <= cur;
      end

      // A timeout in the same cycle as err_clr leaves its bit set.
      timeout_err <= (err_clr ? '0 : timeout_err) | (expire ? cur_oh : '0);
    end
  end

endmodule
